// File: rtl/seg_scan_decoder_if.sv
// Bus bundle for the 7-segment scan decoder: scanned display inputs on one side,
// decoded digit values and event pulses on the other.
interface seg_scan_decoder_if;
    logic [7:0]  seg_com_i;
    logic [6:0]  seg_data_i;
    logic [31:0] digit_val_o;
    logic [7:0]  digit_ok_o;
    logic        frame_done_o;
    logic        com_err_o;
    logic        dbg_hold_o;

    modport slave (
        input  seg_com_i, seg_data_i,
        output digit_val_o, digit_ok_o, frame_done_o, com_err_o, dbg_hold_o
    );

    modport master (
        output seg_com_i, seg_data_i,
        input  digit_val_o, digit_ok_o, frame_done_o, com_err_o, dbg_hold_o
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Capture-side decoder for a multiplexed 8-digit 7-segment bus: waits for each
// {COM, DATA} pattern to settle, then commits its decoded value to one digit slot.
module seg_scan_decoder #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    seg_scan_decoder_if.slave  bus
);
    typedef enum logic {ST_WAIT = 1'b0, ST_HOLD = 1'b1} state_t;

    localparam logic [7:0] SETTLE_MAX  = 8'(SETTLE_CYCLES);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [14:0] s_q;
    logic        s_vld_q;
    logic [7:0]  cnt_q, cnt_d;
    logic        commit_q, commit_d;
    logic [31:0] val_q, val_d;
    logic [7:0]  ok_q, ok_d;
    logic [7:0]  seen_q, seen_d;
    logic        frame_q, frame_d;
    logic        err_q, err_d;

    logic [14:0] sample;
    logic        same;
    logic [7:0]  low;
    logic [7:0]  pos_mask;
    logic        one_low;
    logic [4:0]  dec;
    logic [7:0]  seen_next;

    function automatic logic [4:0] decode(input logic [6:0] seg);
        case (seg)
            7'b1111110: decode = {1'b1, 4'd0};
            7'b0110000: decode = {1'b1, 4'd1};
            7'b1101101: decode = {1'b1, 4'd2};
            7'b1111001: decode = {1'b1, 4'd3};
            7'b0110011: decode = {1'b1, 4'd4};
            7'b1011011: decode = {1'b1, 4'd5};
            7'b1011111: decode = {1'b1, 4'd6};
            7'b1110000: decode = {1'b1, 4'd7};
            7'b1111111: decode = {1'b1, 4'd8};
            7'b1111011: decode = {1'b1, 4'd9};
            default:    decode = {1'b0, 4'hF};
        endcase
    endfunction

    assign sample = {bus.seg_com_i, bus.seg_data_i};
    // The first sample after reset never counts as a repeat, so a pattern present
    // at reset release still has to settle for the full window.
    assign same   = s_vld_q && (sample == s_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        commit_d = 1'b0;
        if (!same) begin
            cnt_d   = 8'd0;
            state_d = ST_WAIT;
        end else begin
            if (cnt_q != SETTLE_MAX) cnt_d = cnt_q + 8'd1;
            unique case (state_q)
                ST_WAIT: if (cnt_d == SETTLE_LAST) begin
                    state_d  = ST_HOLD;
                    commit_d = 1'b1;
                end
                ST_HOLD: state_d = ST_HOLD;
                default: state_d = ST_WAIT;
            endcase
        end
    end

    // Commit uses the registered sample, so a change on the commit edge is harmless.
    always_comb begin
        low       = ~s_q[14:7];
        one_low   = (low != 8'd0) && ((low & (low - 8'd1)) == 8'd0);
        dec       = decode(s_q[6:0]);
        pos_mask  = '0;
        for (int p = 0; p < 8; p++) pos_mask[p] = low[7-p];
        seen_next = seen_q | pos_mask;
        val_d     = val_q;
        ok_d      = ok_q;
        seen_d    = seen_q;
        frame_d   = 1'b0;
        err_d     = 1'b0;
        if (commit_q) begin
            if (one_low) begin
                for (int p = 0; p < 8; p++) begin
                    if (pos_mask[p]) begin
                        val_d[4*p +: 4] = dec[3:0];
                        ok_d[p]         = dec[4];
                    end
                end
                if (seen_next == 8'hFF) begin
                    frame_d = 1'b1;
                    seen_d  = 8'h00;
                end else begin
                    seen_d  = seen_next;
                end
            end else if (low != 8'd0) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_WAIT;
            s_q      <= '0;
            s_vld_q  <= 1'b0;
            cnt_q    <= '0;
            commit_q <= 1'b0;
            val_q    <= '0;
            ok_q     <= '0;
            seen_q   <= '0;
            frame_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= sample;
            s_vld_q  <= 1'b1;
            cnt_q    <= cnt_d;
            commit_q <= commit_d;
            val_q    <= val_d;
            ok_q     <= ok_d;
            seen_q   <= seen_d;
            frame_q  <= frame_d;
            err_q    <= err_d;
        end
    end

    assign bus.digit_val_o  = val_q;
    assign bus.digit_ok_o   = ok_q;
    assign bus.frame_done_o = frame_q;
    assign bus.com_err_o    = err_q;
    assign bus.dbg_hold_o   = (state_q == ST_HOLD);
endmodule
